// File: rtl/rv_pkg.sv
// Shared RV32 core definitions: widths, default reset PC, fetch FSM states and major opcodes.
// The HALT state exists only when IFETCH_MISALIGN_CHECK_EN is defined.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] DefaultResetPc = 32'h0000_0000;

`ifdef IFETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {StFetch, StFlush, StHalt} fetch_state_e;
`else
  typedef enum logic [1:0] {StFetch, StFlush} fetch_state_e;
`endif

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  localparam logic [6:0] OpcLoad   = 7'b000_0011;
  localparam logic [6:0] OpcOpImm  = 7'b001_0011;
  localparam logic [6:0] OpcAuipc  = 7'b001_0111;
  localparam logic [6:0] OpcStore  = 7'b010_0011;
  localparam logic [6:0] OpcOp     = 7'b011_0011;
  localparam logic [6:0] OpcLui    = 7'b011_0111;
  localparam logic [6:0] OpcBranch = 7'b110_0011;
  localparam logic [6:0] OpcJalr   = 7'b110_0111;
  localparam logic [6:0] OpcJal    = 7'b110_1111;
  localparam logic [6:0] OpcSystem = 7'b111_0011;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction memory request/response, redirect and decode handoff.
// master = fetch stage, slave = its environment (memory, execute, decode).
interface instr_fetch_if;

  logic                     imem_req_valid;
  logic                     imem_req_ready;
  logic [rv_pkg::XLEN-1:0]  imem_req_addr;
  logic                     imem_rsp_valid;
  logic [rv_pkg::ILEN-1:0]  imem_rsp_data;
  logic                     redirect_valid;
  logic [rv_pkg::XLEN-1:0]  redirect_pc;
  logic                     dec_valid;
  logic                     dec_ready;
  logic [rv_pkg::ILEN-1:0]  dec_instr;
  logic [rv_pkg::XLEN-1:0]  dec_pc;
  logic                     fetch_misalign;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, fetch_misalign,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, fetch_misalign,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Depth-entry synchronous queue of {pc, instr}; head entry drives rdata directly from storage.
// Clear wins over push and pop in the same cycle.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(Depth):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t    mem_q [Depth];
  fetch_entry_t    mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_eff, pop_eff;

  always_comb begin
    pop_eff  = pop && (count_q != '0);
    push_eff = push && ((count_q != CntW'(Depth)) || pop_eff);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop_eff) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push_eff) - CntW'(pop_eff);
    end
  end

  // Storage is reset so the decode outputs read zero straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(Depth));

endmodule

// File: rtl/instr_fetch.sv
// RV32 fetch stage: PC, request credits, stale-response drop counter and FETCH/FLUSH(/HALT) FSM.
// IFETCH_MISALIGN_CHECK_EN enables the misaligned-redirect halt and fetch_misalign pulse.
module instr_fetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DefaultResetPc,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

  fetch_entry_t    fifo_wdata, fifo_rdata;
  logic [CntW-1:0] fifo_count;
  logic            fifo_empty, fifo_full;
  logic            fifo_push, fifo_clear;
  logic            req_valid, req_hs, redirect_take;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
`endif

  always_comb begin
    // Credits cover both in-flight requests and buffered words, so responses always fit.
    req_valid  = !rst && (state_q == StFetch)
                 && (({1'b0, inflight_q} + {1'b0, fifo_count}) < (CntW + 1)'(DEPTH));
    req_hs     = req_valid && bus.imem_req_ready;
    inflight_d = inflight_q + CntW'(req_hs) - CntW'(bus.imem_rsp_valid);

    state_d    = state_q;
    pc_d       = req_hs ? pc_q + 32'd4 : pc_q;
    drop_cnt_d = drop_cnt_q;
    fifo_push  = 1'b0;
    fifo_clear = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
    misalign_d    = 1'b0;
    redirect_take = bus.redirect_valid && (state_q != StHalt);
`else
    redirect_take = bus.redirect_valid;
`endif

    unique case (state_q)
      StFetch: fifo_push = bus.imem_rsp_valid;
      StFlush: begin
        if (bus.imem_rsp_valid) begin
          drop_cnt_d = drop_cnt_q - CntW'(1);
          if (drop_cnt_q == CntW'(1)) begin
            state_d = StFetch;
          end
        end
      end
      default: ;
    endcase

    if (redirect_take) begin
      fifo_push  = 1'b0;
      fifo_clear = 1'b1;
      drop_cnt_d = inflight_d;
      pc_d       = bus.redirect_pc & ~32'h3;
      state_d    = (inflight_d != '0) ? StFlush : StFetch;
`ifdef IFETCH_MISALIGN_CHECK_EN
      if (bus.redirect_pc[1:0] != 2'b00) begin
        state_d    = StHalt;
        misalign_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef IFETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
  assign bus.fetch_misalign = misalign_q;
`else
  assign bus.fetch_misalign = 1'b0;
`endif

  // Responses are in order, so the oldest outstanding PC is the one at the buffer tail.
  logic [XLEN-1:0] rsp_pc;
  assign rsp_pc = pc_q - {inflight_q, 2'b00};

  assign fifo_wdata = '{pc: rsp_pc, instr: bus.imem_rsp_data};

  fetch_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (bus.dec_ready),
    .clear (fifo_clear),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.dec_valid      = !fifo_empty;
  assign bus.dec_instr      = fifo_rdata.instr;
  assign bus.dec_pc         = fifo_rdata.pc;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: fixed-latency memory model, redirect table, corner sequences.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  typedef struct {
    logic [31:0] target;
    int          lat;
    int          pre;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } redir_vec_t;

  mem_req_t    mq[$];
  logic [31:0] got_pc[$];
  logic [31:0] req_addr[$];
  int          req_cyc[$];
  int          req_pend[$];
  int          cyc = 0;
  int          lat = 1;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, advance, then present this cycle's response.
  task automatic step();
    int pend;
    #1;
    pend = mq.size();
    if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
      mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
      req_addr.push_back(bus.imem_req_addr);
      req_cyc.push_back(cyc);
      req_pend.push_back(pend);
    end
    if (!rst && bus.dec_valid && bus.dec_ready) begin
      got_pc.push_back(bus.dec_pc);
      chk("dec_instr", bus.dec_instr, word_of(bus.dec_pc));
    end
    if (bus.imem_rsp_valid) void'(mq.pop_front());
    @(posedge clk);
    #1;
    cyc++;
    bus.redirect_valid = 1'b0;
    if (rst) mq.delete();
    if (mq.size() > 0 && mq[0].due == cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = word_of(mq[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b1;
    bus.imem_req_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    got_pc.delete();
    req_addr.delete();
    req_cyc.delete();
    req_pend.delete();
    #1;
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    int b = 0;
    while (got_pc.size() < n && b < budget) begin
      step();
      b++;
    end
    if (got_pc.size() < n) chk(name, got_pc.size(), n);
  endtask

  task automatic wait_req(input int n, input int budget, input string name);
    int b = 0;
    while (req_addr.size() < n && b < budget) begin
      step();
      b++;
    end
    if (req_addr.size() < n) chk(name, req_addr.size(), n);
  endtask

  redir_vec_t vecs[$];

  initial begin
    int ng, nr, rc;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b1;
    bus.imem_req_ready = 1'b1;

    vecs.push_back('{target: 32'h0000_0100, lat: 1, pre: 4, exp0: 32'h0000_0100, exp1: 32'h0000_0104});
    vecs.push_back('{target: 32'h0000_0100, lat: 3, pre: 6, exp0: 32'h0000_0100, exp1: 32'h0000_0104});
    vecs.push_back('{target: 32'hFFFF_FFFC, lat: 1, pre: 4, exp0: 32'hFFFF_FFFC, exp1: 32'h0000_0000});
    vecs.push_back('{target: 32'h8000_0010, lat: 2, pre: 5, exp0: 32'h8000_0010, exp1: 32'h8000_0014});
`ifndef IFETCH_MISALIGN_CHECK_EN
    vecs.push_back('{target: 32'h0000_0203, lat: 1, pre: 3, exp0: 32'h0000_0200, exp1: 32'h0000_0204});
`endif

    // Reset values while rst is held.
    lat = 1;
    rst = 1'b1;
    step();
    step();
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h0);
    chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("rst_dec_instr", bus.dec_instr, 32'h0);
    chk("rst_dec_pc", bus.dec_pc, 32'h0);
    chk("rst_misalign", 32'(bus.fetch_misalign), 32'd0);
    rst = 1'b0;
    #1;
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", bus.imem_req_addr, 32'h0);

    // Streaming fetch, 1-cycle memory, decode always ready.
    do_reset();
    wait_got(6, 40, "stream_timeout");
    for (int i = 0; i < 6 && i < got_pc.size(); i++) begin
      chk($sformatf("stream_pc%0d", i), got_pc[i], 32'(4 * i));
      chk($sformatf("stream_req%0d", i), req_addr[i], 32'(4 * i));
    end

    // Mid-run reset discards everything.
    rst = 1'b1;
    step();
    chk("midrst_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("midrst_req_addr", bus.imem_req_addr, 32'h0);
    chk("midrst_dec_pc", bus.dec_pc, 32'h0);

    // Decode back-pressure with DEPTH=2.
    do_reset();
    bus.dec_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("bp_req_count", req_addr.size(), 32'd2);
    chk("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("bp_dec_valid", 32'(bus.dec_valid), 32'd1);
    chk("bp_dec_pc", bus.dec_pc, 32'h0);
    bus.dec_ready = 1'b1;
    wait_got(3, 30, "bp_timeout");
    if (got_pc.size() >= 3) begin
      chk("bp_pc0", got_pc[0], 32'h0);
      chk("bp_pc1", got_pc[1], 32'h4);
      chk("bp_pc2", got_pc[2], 32'h8);
      chk("bp_req2", req_addr[2], 32'h8);
    end

    // Redirect table: stale words never reach decode, next fetch starts at the target.
    foreach (vecs[k]) begin
      do_reset();
      lat = vecs[k].lat;
      for (int i = 0; i < vecs[k].pre; i++) step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = vecs[k].target;
      step();
      ng = got_pc.size();
      nr = req_addr.size();
      wait_req(nr + 2, 40, $sformatf("redir%0d_req_timeout", k));
      wait_got(ng + 2, 40, $sformatf("redir%0d_dec_timeout", k));
      if (req_addr.size() >= nr + 2 && got_pc.size() >= ng + 2) begin
        chk($sformatf("redir%0d_req0", k), req_addr[nr], vecs[k].exp0);
        chk($sformatf("redir%0d_req1", k), req_addr[nr + 1], vecs[k].exp1);
        chk($sformatf("redir%0d_flush_drain", k), req_pend[nr], 32'd0);
        chk($sformatf("redir%0d_dec0", k), got_pc[ng], vecs[k].exp0);
        chk($sformatf("redir%0d_dec1", k), got_pc[ng + 1], vecs[k].exp1);
      end
    end
    lat = 1;

    // Redirect coinciding with a request handshake and a response: one stale word to drop.
    do_reset();
    step();
    chk("same_pre_rsp", 32'(bus.imem_rsp_valid), 32'd1);
    chk("same_pre_req", 32'(bus.imem_req_valid && bus.imem_req_ready), 32'd1);
    rc                 = cyc;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0300;
    step();
    nr = req_addr.size();
    wait_req(nr + 1, 30, "same_req_timeout");
    wait_got(1, 30, "same_dec_timeout");
    if (req_addr.size() > nr && got_pc.size() > 0) begin
      chk("same_first_dec", got_pc[0], 32'h0000_0300);
      chk("same_req_addr", req_addr[nr], 32'h0000_0300);
      chk("same_req_cycle", 32'(req_cyc[nr]), 32'(rc + 2));
    end

    // Redirect with nothing in flight: new address on the very next cycle.
    do_reset();
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0400;
    step();
    chk("idle_redir_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("idle_redir_addr", bus.imem_req_addr, 32'h0000_0400);
    bus.imem_req_ready = 1'b1;

    // Misaligned redirect target.
    do_reset();
    for (int i = 0; i < 3; i++) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0102;
    step();
`ifdef IFETCH_MISALIGN_CHECK_EN
    chk("mis_pulse", 32'(bus.fetch_misalign), 32'd1);
    step();
    chk("mis_pulse_end", 32'(bus.fetch_misalign), 32'd0);
    nr = req_addr.size();
    ng = got_pc.size();
    for (int i = 0; i < 8; i++) step();
    chk("mis_no_req", req_addr.size(), 32'(nr));
    chk("mis_no_dec", got_pc.size(), 32'(ng));
    chk("mis_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("mis_dec_valid", 32'(bus.dec_valid), 32'd0);
`else
    chk("mis_flag_low", 32'(bus.fetch_misalign), 32'd0);
    nr = req_addr.size();
    wait_req(nr + 1, 30, "mis_req_timeout");
    if (req_addr.size() > nr) chk("mis_aligned_req", req_addr[nr], 32'h0000_0100);
    chk("mis_flag_stays_low", 32'(bus.fetch_misalign), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
